// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues icache reads and drives the
// producer side of the IF/ID latch, holding redirects that land during a miss.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic [31:0] npc_o,
  output logic [31:0] iload_o,
  output logic        iien_o,
  output logic        flush_o,
  output logic        fetch_halt_o,
  output logic [31:0] instr_count_o
);

  typedef enum logic [1:0] {
    RUN,
    PEND,
    HALTED
  } state_t;

  localparam logic [31:0] PC_RST = PC_INIT & ~32'h3;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] redir_tgt;
  logic        iien, flush;

  assign redir_tgt = redirect_pc_i & ~32'h3;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    iien    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (halt_i) begin
          state_d = HALTED;
        end else if (redirect_i) begin
          flush = 1'b1;
          if (ihit) begin
            pc_d = redir_tgt;
          end else begin
            // PC holds so the cache keeps servicing the outstanding miss
            tgt_d   = redir_tgt;
            state_d = PEND;
          end
        end else if (ihit && !stall_i) begin
          iien = 1'b1;
          pc_d = pc_q + 32'd4;
        end
      end
      PEND: begin
        if (halt_i) begin
          state_d = HALTED;
        end else begin
          if (redirect_i) begin
            flush = 1'b1;
            tgt_d = redir_tgt;
          end
          if (ihit) begin
            pc_d    = redirect_i ? redir_tgt : tgt_q;
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = HALTED;
      end
    endcase
    cnt_d = cnt_q + {31'b0, iien};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      pc_q    <= PC_RST;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imemREN       = (state_q != HALTED);
  assign imemaddr      = pc_q;
  assign npc_o         = pc_q + 32'd4;
  assign iload_o       = imemload;
  assign iien_o        = iien;
  assign flush_o       = flush;
  assign fetch_halt_o  = (state_q == HALTED);
  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, all
// compared against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam logic [31:0] INIT = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        halt_i = 1'b0;
  logic [31:0] npc_o;
  logic [31:0] iload_o;
  logic        iien_o;
  logic        flush_o;
  logic        fetch_halt_o;
  logic [31:0] instr_count_o;

  fetch_unit #(.PC_INIT(INIT)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .halt_i(halt_i),
    .npc_o(npc_o), .iload_o(iload_o), .iien_o(iien_o), .flush_o(flush_o),
    .fetch_halt_o(fetch_halt_o), .instr_count_o(instr_count_o)
  );

  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // reference model state
  logic [31:0] m_pc, m_tgt, m_count;
  bit          m_pend, m_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = INIT & ~32'h3;
    m_tgt = '0;
    m_count = '0;
    m_pend = 1'b0;
    m_halted = 1'b0;
  endtask

  task automatic check_outputs();
    bit run_accept;
    run_accept = !m_halted && !m_pend && !halt_i && !redirect_i && ihit && !stall_i;
    check("imemREN", imemREN, !m_halted);
    check("imemaddr", imemaddr, m_pc);
    check("npc", npc_o, m_pc + 32'd4);
    check("iload", iload_o, imemload);
    check("iien", iien_o, run_accept);
    check("flush", flush_o, !m_halted && !halt_i && redirect_i);
    check("fetch_halt", fetch_halt_o, m_halted);
    check("count", instr_count_o, m_count);
  endtask

  task automatic model_step();
    logic [31:0] t;
    t = redirect_pc_i & ~32'h3;
    if (m_halted) return;
    if (halt_i) begin
      m_halted = 1'b1;
      m_pend = 1'b0;
    end else if (!m_pend) begin
      if (redirect_i) begin
        if (ihit) m_pc = t;
        else begin
          m_tgt = t;
          m_pend = 1'b1;
        end
      end else if (ihit && !stall_i) begin
        m_pc = m_pc + 32'd4;
        m_count = m_count + 32'd1;
      end
    end else begin
      if (redirect_i) m_tgt = t;
      if (ihit) begin
        m_pc = m_tgt;
        m_pend = 1'b0;
      end
    end
  endtask

  // one clock cycle: drive at negedge, check mid-cycle, advance model at posedge
  task automatic cyc(input bit ih, input bit st, input bit rd,
                     input logic [31:0] rpc, input bit hl);
    ihit = ih;
    stall_i = st;
    redirect_i = rd;
    redirect_pc_i = rpc;
    halt_i = hl;
    imemload = $urandom;
    #1;
    check_outputs();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    ihit = 0; stall_i = 0; redirect_i = 0; halt_i = 0;
    nRST = 1'b0;
    #1;
    model_reset();
    check("rst_addr", imemaddr, INIT);
    check("rst_npc", npc_o, INIT + 32'd4);
    check_outputs();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    bit hl;
    @(negedge CLK);
    do_reset();

    // hit stream from reset
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, '0, 0);
    check("stream_count", instr_count_o, 32'd4);
    check("stream_addr", imemaddr, 32'h110);

    // stall at 0x10
    cyc(1, 0, 1, 32'h10, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, '0, 0);
    check("stall_hold", imemaddr, 32'h10);
    cyc(1, 0, 0, '0, 0);
    check("stall_release", imemaddr, 32'h14);

    // redirect on hit, low bits ignored
    cyc(1, 0, 1, 32'h20, 0);
    cyc(1, 1, 1, 32'h403, 0);
    check("redir_hit", imemaddr, 32'h400);

    // redirect during a miss
    cyc(1, 0, 1, 32'h40, 0);
    cyc(0, 0, 1, 32'h80, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, '0, 0);
    check("miss_hold", imemaddr, 32'h40);
    cyc(1, 0, 0, '0, 0);
    check("miss_resume", imemaddr, 32'h80);

    // second redirect mid-miss wins
    cyc(0, 0, 1, 32'h100, 0);
    cyc(0, 0, 0, '0, 0);
    cyc(0, 0, 1, 32'hC0, 0);
    cyc(0, 0, 0, '0, 0);
    cyc(1, 0, 0, '0, 0);
    check("last_redir", imemaddr, 32'hC0);

    // pc wrap
    cyc(1, 0, 1, 32'hFFFF_FFFC, 0);
    cyc(1, 0, 0, '0, 0);
    check("wrap", imemaddr, 32'h0);

    // async reset mid-PEND
    cyc(0, 0, 1, 32'h800, 0);
    cyc(0, 0, 0, '0, 0);
    #3;
    nRST = 1'b0;
    #1;
    check("async_rst_addr", imemaddr, INIT);
    check("async_rst_count", instr_count_o, 32'd0);
    @(negedge CLK);
    do_reset();
    cyc(1, 0, 0, '0, 0);
    check("post_rst_addr", imemaddr, INIT + 32'd4);

    // halt beats a redirect; later redirects ignored
    cyc(1, 0, 1, 32'h500, 1);
    check("halt_ren", imemREN, 1'b0);
    check("halt_flag", fetch_halt_o, 1'b1);
    check("halt_pc", imemaddr, INIT + 32'd4);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 32'h600, 1);
    cyc(1, 0, 1, 32'h700, 0);
    check("halt_frozen", imemaddr, INIT + 32'd4);

    // randomized traffic in several reset epochs
    for (int e = 0; e < 4; e++) begin
      do_reset();
      hl = 0;
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 299) == 0) hl = 1;
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0, $urandom, hl);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
